nonce_sweep_feeder: RTL and testbench

- Work-feeding front end for the stage-2 hasher pipeline (main_hasher). It drives the hasher's write side.
- Accepts one work unit over a valid/ready handshake: the stage-1 digest, the header tail fields and an inclusive nonce range.
- Issues one hasher write beat per cycle, one nonce per beat, then issues PIPE_DEPTH flush beats so the last real result reaches the hasher output.
- Signals done when the flush completes. The result collector uses flush_out to discard flush beats.

---
 rtl/nonce_sweep_feeder.sv | 172 +++++++++++++++++
 tb/tb_nonce_sweep_feeder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_feeder.sv
// Nonce sweep feeder: accepts one work unit, drives the hasher write side with
// one nonce per beat across an inclusive range, then issues PIPE_DEPTH flush
// beats so the last real result drains out of the hasher pipeline.
module nonce_sweep_feeder #(
   parameter int unsigned PIPE_DEPTH = 128,
   parameter int unsigned CNT_W      = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [255:0] load_digest,
   input  logic [31:0]  load_merkle_tail,
   input  logic [31:0]  load_timestamp,
   input  logic [31:0]  load_target,
   input  logic [31:0]  load_nonce_start,
   input  logic [31:0]  load_nonce_end,
   input  logic         pause,
   input  logic         abort,
   output logic         write_en,
   output logic [255:0] digest_1,
   output logic [31:0]  merkle_tail,
   output logic [31:0]  timestamp,
   output logic [31:0]  target,
   output logic [31:0]  nonce,
   output logic         flush_out,
   output logic         busy,
   output logic         done,
   output logic         range_err
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(PIPE_DEPTH);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

   state_e           state_q, state_d;
   logic [31:0]      cur_q, cur_d;
   logic [31:0]      end_q, end_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             abort_q, abort_d;
   logic             abort_now;

   logic             write_en_d, flush_d, busy_d, done_d, range_err_d;
   logic [31:0]      nonce_d, merkle_d, timestamp_d, target_d;
   logic [255:0]     digest_d;

   assign load_ready = (state_q == StIdle);

   // An abort seen while paused is remembered until the next issuing edge.
   assign abort_now = abort | abort_q;

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      end_d       = end_q;
      cnt_d       = cnt_q;
      abort_d     = abort_q;
      write_en_d  = 1'b0;
      flush_d     = 1'b0;
      done_d      = 1'b0;
      range_err_d = 1'b0;
      nonce_d     = nonce;
      digest_d    = digest_1;
      merkle_d    = merkle_tail;
      timestamp_d = timestamp;
      target_d    = target;

      unique case (state_q)
         StIdle: begin
            if (load_valid) begin
               if (load_nonce_end < load_nonce_start) begin
                  range_err_d = 1'b1;
               end else begin
                  digest_d    = load_digest;
                  merkle_d    = load_merkle_tail;
                  timestamp_d = load_timestamp;
                  target_d    = load_target;
                  cur_d       = load_nonce_start;
                  end_d       = load_nonce_end;
                  abort_d     = 1'b0;
                  state_d     = StRun;
               end
            end
         end
         StRun: begin
            if (pause) begin
               abort_d = abort_now;
            end else if (cur_q == end_q) begin
               // End nonce is always issued as real, even on an abort edge.
               write_en_d = 1'b1;
               nonce_d    = cur_q;
               cnt_d      = DepthCnt;
               abort_d    = 1'b0;
               state_d    = StDrain;
            end else if (abort_now) begin
               // Aborting edge becomes the first flush beat.
               write_en_d = 1'b1;
               flush_d    = 1'b1;
               abort_d    = 1'b0;
               if (DepthCnt == CntOne) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d   = DepthCnt - CntOne;
                  state_d = StDrain;
               end
            end else begin
               write_en_d = 1'b1;
               nonce_d    = cur_q;
               cur_d      = cur_q + 32'd1;
            end
         end
         StDrain: begin
            if (!pause) begin
               write_en_d = 1'b1;
               flush_d    = 1'b1;
               cnt_d      = cnt_q - CntOne;
               if (cnt_q == CntOne) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StRun) || (state_d == StDrain);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= StIdle;
         cur_q       <= '0;
         end_q       <= '0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         write_en    <= 1'b0;
         flush_out   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         range_err   <= 1'b0;
         nonce       <= '0;
         digest_1    <= '0;
         merkle_tail <= '0;
         timestamp   <= '0;
         target      <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         end_q       <= end_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         write_en    <= write_en_d;
         flush_out   <= flush_d;
         busy        <= busy_d;
         done        <= done_d;
         range_err   <= range_err_d;
         nonce       <= nonce_d;
         digest_1    <= digest_d;
         merkle_tail <= merkle_d;
         timestamp   <= timestamp_d;
         target      <= target_d;
      end
   end

endmodule

// File: tb/tb_nonce_sweep_feeder.sv
// Bench for nonce_sweep_feeder: a beat-queue model of each sweep is stepped on
// every rising edge and all outputs are compared on every falling edge.
module tb_nonce_sweep_feeder;

   localparam int unsigned Depth = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [255:0] load_digest = '0;
   logic [31:0]  load_merkle_tail = '0;
   logic [31:0]  load_timestamp = '0;
   logic [31:0]  load_target = '0;
   logic [31:0]  load_nonce_start = '0;
   logic [31:0]  load_nonce_end = '0;
   logic         pause = 1'b0;
   logic         abort = 1'b0;
   logic         write_en;
   logic [255:0] digest_1;
   logic [31:0]  merkle_tail, timestamp, target, nonce;
   logic         flush_out, busy, done, range_err;

   nonce_sweep_feeder #(
      .PIPE_DEPTH(Depth),
      .CNT_W     (8)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .load_valid       (load_valid),
      .load_ready       (load_ready),
      .load_digest      (load_digest),
      .load_merkle_tail (load_merkle_tail),
      .load_timestamp   (load_timestamp),
      .load_target      (load_target),
      .load_nonce_start (load_nonce_start),
      .load_nonce_end   (load_nonce_end),
      .pause            (pause),
      .abort            (abort),
      .write_en         (write_en),
      .digest_1         (digest_1),
      .merkle_tail      (merkle_tail),
      .timestamp        (timestamp),
      .target           (target),
      .nonce            (nonce),
      .flush_out        (flush_out),
      .busy             (busy),
      .done             (done),
      .range_err        (range_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        fl;
      logic [31:0] n;
   } beat_t;

   beat_t        mq[$];
   bit           m_idle = 1'b1;
   bit           m_done_next = 1'b0;
   logic [31:0]  m_end = '0;
   logic         e_we = 0, e_fl = 0, e_busy = 0, e_done = 0, e_rerr = 0;
   logic [31:0]  e_nonce = '0, e_mt = '0, e_ts = '0, e_tg = '0;
   logic [255:0] e_dig = '0;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [31:0]  real_log[$];
   int           flush_cnt = 0, done_cnt = 0, rerr_cnt = 0, gap_cnt = 0;

   task automatic model_reset();
      mq.delete();
      m_idle = 1'b1; m_done_next = 1'b0; m_end = '0;
      e_we = 0; e_fl = 0; e_busy = 0; e_done = 0; e_rerr = 0;
      e_nonce = '0; e_mt = '0; e_ts = '0; e_tg = '0; e_dig = '0;
   endtask

   // Expected outputs after one rising edge, from the inputs present at it.
   task automatic model_step();
      beat_t b;
      if (!RST) begin
         model_reset();
         return;
      end
      e_we = 0; e_fl = 0; e_done = 0; e_rerr = 0;
      if (m_done_next) begin
         m_done_next = 1'b0;
         m_idle      = 1'b1;
         e_done      = 1'b1;
      end else if (m_idle) begin
         if (load_valid) begin
            if (load_nonce_end < load_nonce_start) begin
               e_rerr = 1'b1;
            end else begin
               e_dig = load_digest; e_mt = load_merkle_tail;
               e_ts = load_timestamp; e_tg = load_target;
               m_end = load_nonce_end;
               mq.delete();
               for (longint v = longint'(load_nonce_start); v <= longint'(load_nonce_end); v++) begin
                  b.fl = 1'b0; b.n = 32'(v);
                  mq.push_back(b);
               end
               repeat (Depth) begin
                  b.fl = 1'b1; b.n = '0;
                  mq.push_back(b);
               end
               m_idle = 1'b0;
            end
         end
      end else if (mq.size() > 0 && !pause) begin
         if (abort && !mq[0].fl && mq[0].n != m_end) begin
            while (mq.size() > 0 && !mq[0].fl) void'(mq.pop_front());
         end
         b = mq.pop_front();
         e_we = 1'b1;
         e_fl = b.fl;
         if (!b.fl) e_nonce = b.n;
         if (mq.size() == 0) m_done_next = 1'b1;
      end
      e_busy = !m_idle && (mq.size() > 0);
   endtask

   // ---------------- checking ----------------
   task automatic check1(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout want event at %0t", name, $time);
   endtask

   task automatic check_all();
      check1("write_en", write_en, e_we);
      check1("flush_out", flush_out, e_fl);
      check1("nonce", nonce, e_nonce);
      check1("busy", busy, e_busy);
      check1("done", done, e_done);
      check1("range_err", range_err, e_rerr);
      check1("load_ready", load_ready, m_idle);
      check1("digest_1", digest_1, e_dig);
      check1("merkle_tail", merkle_tail, e_mt);
      check1("timestamp", timestamp, e_ts);
      check1("target", target, e_tg);
   endtask

   // One clock: model at the rising edge, compare and log at the falling edge.
   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_all();
      if (write_en && !flush_out) real_log.push_back(nonce);
      if (write_en && flush_out) flush_cnt++;
      if (busy && !write_en) gap_cnt++;
      if (done) done_cnt++;
      if (range_err) rerr_cnt++;
   endtask

   task automatic do_load(input logic [31:0] s, input logic [31:0] e);
      bit ok = 1'b0;
      pause = 1'b0; abort = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (load_ready) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) fail_now("load_ready_wait");
      load_valid       = 1'b1;
      load_digest      = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
      load_merkle_tail = $urandom;
      load_timestamp   = $urandom;
      load_target      = $urandom;
      load_nonce_start = s;
      load_nonce_end   = e;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic wait_idle(input int rnd);
      bit ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (rnd != 0) begin
            pause = ($urandom_range(99) < 25);
            abort = !pause && ($urandom_range(99) < 4);
         end
         tick();
         if (load_ready) begin ok = 1'b1; break; end
      end
      pause = 1'b0; abort = 1'b0;
      if (!ok) fail_now("sweep_end_wait");
   endtask

   task automatic wait_real(input int base, input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (real_log.size() - base >= n) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) fail_now("real_beat_wait");
   endtask

   task automatic check_reals(input string name, input int base, input logic [31:0] first,
                              input int cnt);
      check1({name, "_real_cnt"}, 256'(real_log.size() - base), 256'(cnt));
      for (int i = 0; i < cnt && base + i < real_log.size(); i++)
         check1({name, "_real_val"}, real_log[base + i], first + 32'(i));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rb, fb, db, gb, eb;
      logic [31:0] s, e;

      // Reset state, including load_ready held high during reset.
      #1;
      check_all();
      check1("rst_ready_lit", load_ready, 1'b1);
      tick();
      tick();
      RST = 1'b1;
      tick();

      // Plain sweep 5..7.
      rb = real_log.size(); fb = flush_cnt; db = done_cnt; gb = gap_cnt;
      do_load(32'd5, 32'd7);
      wait_idle(0);
      check_reals("t1", rb, 32'd5, 3);
      check1("t1_flush_cnt", 256'(flush_cnt - fb), 256'(Depth));
      check1("t1_done_cnt", 256'(done_cnt - db), 256'd1);
      check1("t1_gap_cnt", 256'(gap_cnt - gb), 256'd1);
      check1("t1_last_nonce", nonce, 32'd7);

      // Pause for two cycles after nonce 6.
      rb = real_log.size(); fb = flush_cnt; db = done_cnt; gb = gap_cnt;
      do_load(32'd5, 32'd7);
      wait_real(rb, 2);
      pause = 1'b1;
      tick();
      tick();
      pause = 1'b0;
      wait_idle(0);
      check_reals("t2", rb, 32'd5, 3);
      check1("t2_flush_cnt", 256'(flush_cnt - fb), 256'(Depth));
      check1("t2_gap_cnt", 256'(gap_cnt - gb), 256'd3);
      check1("t2_done_cnt", 256'(done_cnt - db), 256'd1);

      // Top of the nonce space, then a single-nonce range.
      rb = real_log.size(); fb = flush_cnt;
      do_load(32'hFFFF_FFFE, 32'hFFFF_FFFF);
      wait_idle(0);
      check_reals("t3", rb, 32'hFFFF_FFFE, 2);
      check1("t3_flush_cnt", 256'(flush_cnt - fb), 256'(Depth));
      rb = real_log.size();
      do_load(32'h10, 32'h10);
      wait_idle(0);
      check_reals("t3b", rb, 32'h10, 1);

      // Inverted range is rejected, then a valid load is accepted.
      rb = real_log.size(); eb = rerr_cnt; fb = flush_cnt;
      do_load(32'd9, 32'd3);
      repeat (3) tick();
      check1("t4_rerr_cnt", 256'(rerr_cnt - eb), 256'd1);
      check1("t4_no_beats", 256'(real_log.size() - rb + flush_cnt - fb), 256'd0);
      do_load(32'd1, 32'd2);
      wait_idle(0);
      check_reals("t4b", rb, 32'd1, 2);

      // Abort while nonce 3 is on the outputs.
      rb = real_log.size(); fb = flush_cnt; db = done_cnt;
      do_load(32'd0, 32'd100);
      wait_real(rb, 4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle(0);
      check_reals("t5", rb, 32'd0, 4);
      check1("t5_flush_cnt", 256'(flush_cnt - fb), 256'(Depth));
      check1("t5_done_cnt", 256'(done_cnt - db), 256'd1);
      check1("t5_held_nonce", nonce, 32'd3);

      // Abort on the edge that issues the end nonce.
      rb = real_log.size(); fb = flush_cnt;
      do_load(32'd20, 32'd22);
      wait_real(rb, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle(0);
      check_reals("t5b", rb, 32'd20, 3);
      check1("t5b_flush_cnt", 256'(flush_cnt - fb), 256'(Depth));

      // Asynchronous reset in the middle of the flush.
      fb = flush_cnt;
      do_load(32'd5, 32'd7);
      for (int i = 0; i < 300 && flush_cnt - fb < 2; i++) tick();
      check1("t6_in_drain", busy, 1'b1);
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      check_all();
      check1("t6_we_lit", write_en, 1'b0);
      check1("t6_flush_lit", flush_out, 1'b0);
      tick();
      RST = 1'b1;
      db = done_cnt;
      repeat (8) tick();
      check1("t6_no_done", 256'(done_cnt - db), 256'd0);
      check1("t6_ready", load_ready, 1'b1);

      // Randomised sweeps with random pause and abort.
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(3))
            0:       s = 32'hFFFF_FFF0 + 32'($urandom_range(15));
            1:       s = $urandom;
            default: s = 32'($urandom_range(1000));
         endcase
         e = s + 32'($urandom_range(10));
         if (e < s) e = 32'hFFFF_FFFF;
         if ($urandom_range(99) < 15 && s != 0) e = s - 32'd1 - 32'($urandom_range(5));
         if (e > s && s == 0) e = s;
         do_load(s, e);
         wait_idle(1);
         repeat ($urandom_range(2)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
